// File: rtl/mix_columns_seq_if.sv
// Valid/ready bundle for the MixColumns engine.
// master drives the input side and out_ready; slave is the engine.
interface mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic         inv;
    logic [127:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;

    modport master (
        output in_valid,
        output inv,
        output data_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data_out
    );

    modport slave (
        input  in_valid,
        input  inv,
        input  data_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data_out
    );
endinterface

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns / InvMixColumns engine.
// COLS_PER_CYCLE columns per clock, column 3 first, in place.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit SUPPORT_INV    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    mix_columns_seq_if.slave bus
);

    localparam int         N    = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST = 2'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t       r_fsm;
    state_t       w_fsm_nxt;
    logic [127:0] r_state;
    logic [127:0] w_state_nxt;
    logic [1:0]   r_cnt;
    logic         r_inv;
    logic         w_use_inv;
    logic         w_accept;
    logic         w_last;
    logic [1:0]   w_col_idx;
    logic [31:0]  w_col;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3;
        logic [7:0] t0, t1, t2, t3;
        s0 = c[31:24];
        s1 = c[23:16];
        s2 = c[15:8];
        s3 = c[7:0];
        t0 = xtime(s0);
        t1 = xtime(s1);
        t2 = xtime(s2);
        t3 = xtime(s3);
        return {t0 ^ t1 ^ s1 ^ s2 ^ s3,
                s0 ^ t1 ^ t2 ^ s2 ^ s3,
                s0 ^ s1 ^ t2 ^ t3 ^ s3,
                t0 ^ s0 ^ s1 ^ s2 ^ t3};
    endfunction

    // 9, b, d, e multiples come from the x2/x4/x8 xtime chain.
    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] s  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            s[i]  = c[31-8*i -: 8];
            x2    = xtime(s[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ s[i];
            mb[i] = x8 ^ x2 ^ s[i];
            md[i] = x8 ^ x4 ^ s[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    assign w_accept  = (r_fsm == IDLE) && bus.in_valid;
    assign w_last    = (r_cnt == LAST);
    assign w_use_inv = SUPPORT_INV && r_inv;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_fsm_nxt = r_fsm;
        unique case (r_fsm)
            IDLE: if (bus.in_valid) w_fsm_nxt = BUSY;
            BUSY: if (w_last) w_fsm_nxt = DONE;
            DONE: if (bus.out_ready) w_fsm_nxt = IDLE;
            default: w_fsm_nxt = IDLE;
        endcase
    end

    // FSM outputs, decoded from the state register only
    always_comb begin
        bus.in_ready  = (r_fsm == IDLE);
        bus.out_valid = (r_fsm == DONE);
    end

    assign bus.data_out = r_state;

    // Transform the columns selected by the counter this cycle
    always_comb begin
        w_state_nxt = r_state;
        w_col_idx   = 2'd0;
        w_col       = 32'd0;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            w_col_idx = 2'(3 - int'(r_cnt) * COLS_PER_CYCLE - j);
            w_col     = r_state[32*w_col_idx +: 32];
            w_state_nxt[32*w_col_idx +: 32] =
                w_use_inv ? inv_col(w_col) : fwd_col(w_col);
        end
    end

    // State, counter and mode registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= 128'h0;
            r_cnt   <= 2'd0;
            r_inv   <= 1'b0;
        end else if (w_accept) begin
            r_state <= bus.data_in;
            r_cnt   <= 2'd0;
            r_inv   <= SUPPORT_INV && bus.inv;
        end else if (r_fsm == BUSY) begin
            r_state <= w_state_nxt;
            r_cnt   <= r_cnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Randomised bench for mix_columns_seq against a GF(2^8) matrix model.
// Four instances: C=1,2,4 with inverse, and C=1 forward-only.
module tb_mix_columns_seq;

    localparam logic [127:0] FA = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FB = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] WC = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;
    localparam logic [127:0] WD = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;

    logic         clk = 1'b0;
    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;

    logic         s_rst  [4];
    logic         s_iv   [4];
    logic         s_mode [4];
    logic         s_ordy [4];
    logic [127:0] s_in   [4];
    logic         s_ir   [4];
    logic         s_ov   [4];
    logic [127:0] s_dout [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int C  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 1;
        localparam bit SI = (g != 3);
        mix_columns_seq_if u_if ();
        assign u_if.in_valid  = s_iv[g];
        assign u_if.inv       = s_mode[g];
        assign u_if.data_in   = s_in[g];
        assign u_if.out_ready = s_ordy[g];
        assign s_ir[g]        = u_if.in_ready;
        assign s_ov[g]        = u_if.out_valid;
        assign s_dout[g]      = u_if.data_out;
        mix_columns_seq #(
            .COLS_PER_CYCLE(C),
            .SUPPORT_INV   (SI)
        ) u_dut (
            .clk  (clk),
            .rst_n(s_rst[g]),
            .bus  (u_if)
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_mc(input logic [127:0] x,
                                            input logic m);
        logic [7:0]   cf [4];
        logic [7:0]   s  [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (m) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else   cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) s[j] = x[32*c+24-8*j +: 8];
            for (int i = 0; i < 4; i++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(cf[(j - i + 4) % 4], s[j]);
                r[32*c+24-8*i +: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic int nof(input logic [1:0] d);
        case (d)
            2'd1:    return 2;
            2'd2:    return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [127:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input logic [1:0] d, output logic [127:0] y,
                             output int lat);
        lat = 0;
        while (!s_ov[d] && lat < 40) begin
            tick();
            lat++;
        end
        y = s_dout[d];
    endtask

    task automatic send(input logic [1:0] d, input logic [127:0] x,
                        input logic m, output logic [127:0] y,
                        output int lat);
        int t;
        s_in[d]   = x;
        s_mode[d] = m;
        s_iv[d]   = 1'b1;
        t = 0;
        while (!s_ir[d] && t < 40) begin
            tick();
            t++;
        end
        tick();
        s_iv[d]   = 1'b0;
        s_in[d]   = rnd();
        s_mode[d] = ~m;
        wait_done(d, y, lat);
    endtask

    task automatic drain(input logic [1:0] d);
        s_ordy[d] = 1'b1;
        tick();
        s_ordy[d] = 1'b0;
    endtask

    task automatic run_all(input logic [1:0] d);
        logic [127:0] dx [5];
        logic [127:0] de [5];
        logic         dm [5];
        logic [127:0] x, y, z;
        logic         m, si;
        int           lat, t, prev, n, lo, hi;
        si = (d != 2'd3);
        n  = nof(d);
        dx = '{FA, FB, WC, FA, FA};
        dm = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        de = '{FB, FA, WD, FB, FB};
        lo = si ? 0 : 3;
        hi = si ? 3 : 5;
        for (int k = lo; k < hi; k++) begin
            send(d, dx[k], dm[k], y, lat);
            chk($sformatf("dir%0d.%0d", d, k), y, de[k]);
            chk($sformatf("lat%0d.%0d", d, k), 128'(lat), 128'(n));
            drain(d);
        end

        send(d, FA, 1'b0, y, lat);
        for (int k = 0; k < 10; k++) begin
            s_iv[d]   = 1'($urandom_range(0, 1));
            s_mode[d] = 1'($urandom_range(0, 1));
            s_in[d]   = rnd();
            tick();
            chk($sformatf("bp_dout%0d", d), s_dout[d], FB);
            chk($sformatf("bp_ir%0d", d), 128'(s_ir[d]), 128'(0));
            chk($sformatf("bp_ov%0d", d), 128'(s_ov[d]), 128'(1));
        end
        s_iv[d] = 1'b0;
        drain(d);
        chk($sformatf("bp_idle%0d", d), 128'(s_ir[d]), 128'(1));
        chk($sformatf("bp_ovlo%0d", d), 128'(s_ov[d]), 128'(0));

        s_in[d]   = rnd();
        s_mode[d] = 1'b1;
        s_iv[d]   = 1'b1;
        tick();
        s_iv[d] = 1'b0;
        if (n > 1) tick();
        #1 s_rst[d] = 1'b0;
        #1;
        chk($sformatf("rst_ov%0d", d), 128'(s_ov[d]), 128'(0));
        chk($sformatf("rst_ir%0d", d), 128'(s_ir[d]), 128'(1));
        chk($sformatf("rst_dout%0d", d), s_dout[d], 128'h0);
        @(negedge clk);
        s_rst[d]  = 1'b1;
        x         = rnd();
        s_in[d]   = x;
        s_mode[d] = 1'b0;
        s_iv[d]   = 1'b1;
        tick();
        s_iv[d] = 1'b0;
        chk($sformatf("rst_acc%0d", d), 128'(s_ir[d]), 128'(0));
        wait_done(d, y, lat);
        chk($sformatf("rst_new%0d", d), y, ref_mc(x, 1'b0));
        chk($sformatf("rst_lat%0d", d), 128'(lat), 128'(n));
        drain(d);

        for (int k = 0; k < 8; k++) begin
            x = rnd();
            send(d, x, 1'b0, y, lat);
            chk($sformatf("fwd%0d", d), y, ref_mc(x, 1'b0));
            drain(d);
            send(d, y, 1'b1, z, lat);
            drain(d);
            chk($sformatf("rtrip%0d", d), z, si ? x : ref_mc(y, 1'b0));
        end

        s_ordy[d] = 1'b1;
        s_iv[d]   = 1'b1;
        prev      = 0;
        for (int i = 0; i < 1000; i++) begin
            x         = rnd();
            m         = 1'(i & 1);
            s_in[d]   = x;
            s_mode[d] = m;
            t = 0;
            while (!s_ir[d] && t < 40) begin
                tick();
                t++;
            end
            tick();
            wait_done(d, y, lat);
            chk($sformatf("b2b%0d.%0d", d, i), y, ref_mc(x, m && si));
            if (i > 0)
                chk($sformatf("ii%0d.%0d", d, i),
                    128'(cyc - prev), 128'(n + 2));
            prev = cyc;
        end
        s_iv[d] = 1'b0;
        tick();
        s_ordy[d] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            s_rst[i]  = 1'b0;
            s_iv[i]   = 1'b0;
            s_mode[i] = 1'b0;
            s_ordy[i] = 1'b0;
            s_in[i]   = '0;
        end
        #12;
        for (int i = 0; i < 4; i++) begin
            s_in[i] = rnd();
            chk($sformatf("r_ir%0d", i), 128'(s_ir[i]), 128'(1));
            chk($sformatf("r_ov%0d", i), 128'(s_ov[i]), 128'(0));
            chk($sformatf("r_dout%0d", i), s_dout[i], 128'h0);
        end
        #11;
        for (int i = 0; i < 4; i++) s_rst[i] = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) run_all(2'(i));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
